// File: rtl/status_reg.sv
// 6502 processor status register (P): merges ALU flag updates, flag
// instructions, BIT and PLP into the flag set, and forms the push image.
module status_reg (
  input  logic       clk,
  input  logic       reset,
  input  logic       upd_en,
  input  logic [3:0] upd_mask,
  input  logic [7:0] alu_out,
  input  logic       carry_out,
  input  logic       overflow,
  input  logic [2:0] flag_op,
  input  logic       bit_en,
  input  logic [7:0] bit_data,
  input  logic       plp_en,
  input  logic [7:0] plp_data,
  input  logic       php_brk,
  output logic [7:0] p_out,
  output logic       flag_c,
  output logic       flag_z,
  output logic       flag_i,
  output logic       flag_d,
  output logic       flag_v,
  output logic       flag_n,
  output logic       irq_mask,
  output logic       upd_pending
);

  typedef enum logic [2:0] {
    FOP_NONE = 3'd0,
    FOP_CLC  = 3'd1,
    FOP_SEC  = 3'd2,
    FOP_CLI  = 3'd3,
    FOP_SEI  = 3'd4,
    FOP_CLV  = 3'd5,
    FOP_CLD  = 3'd6,
    FOP_SED  = 3'd7
  } flag_op_t;

  logic       c_q, z_q, i_q, d_q, v_q, n_q;
  logic       c_d, z_d, i_d, d_d, v_d, n_d;
  logic       pend_valid, pend_valid_d;
  logic [3:0] pend_mask, pend_mask_d;
  logic       irq_mask_q;

  // Sources applied lowest priority first so higher ones overwrite only
  // the flags they touch.
  always_comb begin
    c_d = c_q;
    z_d = z_q;
    i_d = i_q;
    d_d = d_q;
    v_d = v_q;
    n_d = n_q;

    if (pend_valid) begin
      if (pend_mask[0]) c_d = carry_out;
      if (pend_mask[1]) z_d = (alu_out == 8'h00);
      if (pend_mask[2]) v_d = overflow;
      if (pend_mask[3]) n_d = alu_out[7];
    end

    if (bit_en) begin
      n_d = bit_data[7];
      v_d = bit_data[6];
    end

    case (flag_op_t'(flag_op))
      FOP_CLC: c_d = 1'b0;
      FOP_SEC: c_d = 1'b1;
      FOP_CLI: i_d = 1'b0;
      FOP_SEI: i_d = 1'b1;
      FOP_CLV: v_d = 1'b0;
      FOP_CLD: d_d = 1'b0;
      FOP_SED: d_d = 1'b1;
      default: ;
    endcase

    if (plp_en) begin
      c_d = plp_data[0];
      z_d = plp_data[1];
      i_d = plp_data[2];
      d_d = plp_data[3];
      v_d = plp_data[6];
      n_d = plp_data[7];
    end

    pend_valid_d = upd_en;
    pend_mask_d  = upd_en ? upd_mask : pend_mask;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      c_q        <= 1'b0;
      z_q        <= 1'b0;
      i_q        <= 1'b1;
      d_q        <= 1'b0;
      v_q        <= 1'b0;
      n_q        <= 1'b0;
      pend_valid <= 1'b0;
      pend_mask  <= '0;
      irq_mask_q <= 1'b1;
    end else begin
      c_q        <= c_d;
      z_q        <= z_d;
      i_q        <= i_d;
      d_q        <= d_d;
      v_q        <= v_d;
      n_q        <= n_d;
      pend_valid <= pend_valid_d;
      pend_mask  <= pend_mask_d;
      irq_mask_q <= i_q;
    end
  end

  assign flag_c      = c_q;
  assign flag_z      = z_q;
  assign flag_i      = i_q;
  assign flag_d      = d_q;
  assign flag_v      = v_q;
  assign flag_n      = n_q;
  assign irq_mask    = irq_mask_q;
  assign upd_pending = pend_valid;
  assign p_out       = {n_q, v_q, 1'b1, php_brk, d_q, i_q, z_q, c_q};

endmodule

// File: doc/status_reg.md
# status_reg

6502 processor status register (P) for the NES CPU core. Sits directly downstream of the ALU and consumes its registered result and carry/overflow flags. Derives Z and N from the ALU result and merges them with flag-instruction, PLP and BIT updates. Supplies the carry input back to the ALU, the flag vector to branch logic, and the push image for PHP/BRK/IRQ.

## Interface
Parameters: none.

Ports:
- clk  in  1  core clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- upd_en  in  1  ALU op issued this cycle. Its flags must be captured from the ALU outputs one cycle later.
- upd_mask  in  4  flags to update from that op: [3]=N [2]=V [1]=Z [0]=C
- alu_out  in  8  registered ALU result
- carry_out  in  1  registered ALU carry
- overflow  in  1  registered ALU overflow
- flag_op  in  3  0=none 1=CLC 2=SEC 3=CLI 4=SEI 5=CLV 6=CLD 7=SED
- bit_en  in  1  BIT instruction: load N,V from bit_data now
- bit_data  in  8  memory operand for BIT
- plp_en  in  1  load P from plp_data (PLP/RTI)
- plp_data  in  8  pulled status byte
- php_brk  in  1  B bit value placed in p_out (1 for PHP/BRK, 0 for IRQ/NMI)
- p_out  out  8  push image {N,V,1,B,D,I,Z,C}, where B = php_brk (combinational on that bit only)
- flag_c, flag_z, flag_i, flag_d, flag_v, flag_n  out  1 each  current flags
- irq_mask  out  1  I flag as seen by IRQ polling
- upd_pending  out  1  an ALU flag update is queued for the next edge

## Operation
- ALU outputs lag their inputs by one cycle. On upd_en, the block latches upd_mask into pend_mask and sets pend_valid.
- On the next edge with pend_valid set, the block updates the masked flags:
  - C ← carry_out
  - V ← overflow
  - Z ← (alu_out == 8'h00)
  - N ← alu_out[7]
- The pipeline is fully pipelined: upd_en may be asserted every cycle. Each op applies exactly one edge after issue, in issue order, with no stall.
- pend_valid clears after applying unless upd_en is asserted again in the same cycle.
- bit_en: N ← bit_data[7], V ← bit_data[6] on the same edge. Z is not touched here; the issuer sends a separate upd_en with mask 4'b0010 for the AND result.
- flag_op sets or clears its single flag on the same edge.
- plp_en: C,Z,I,D,V,N ← plp_data[0,1,2,3,6,7]. plp_data bits 5 and 4 are ignored.
- Precedence when sources collide on one edge, highest first:
  - plp_en
  - flag_op
  - bit_en
  - pending ALU update
  
  A lower source still updates any flags that no higher source touches.
- An upd_en issued in the same cycle as plp_en stays queued and applies on the following edge, on top of the pulled value.
- D is stored and reported only; no decimal arithmetic exists.
- irq_mask is flag_i delayed by one register stage. This models the 6502 one-instruction delay of CLI/SEI/PLP on IRQ recognition.

## Timing
- Reset values (edge with reset=1):
  - C=Z=D=V=N=0, I=1
  - pend_valid=0, pend_mask=0
  - irq_mask=1
  - p_out=8'h24 with php_brk=0
- Reset overrides every input on that edge. A queued ALU update is discarded and is never applied after reset deasserts.
- Latency:
  - upd_en at edge N → flags visible after edge N+1
  - flag_op / bit_en / plp_en → visible after the same edge
  - irq_mask → one further edge
- upd_pending = pend_valid (registered).
- Outputs are registered, except that p_out[4] follows php_brk combinationally. p_out[5] is always 1.

## Test plan
- Reset: assert reset for 2 cycles → p_out=8'h24, flag_i=1, irq_mask=1, upd_pending=0.
- Single update: upd_en with mask 4'hF; next cycle alu_out=8'h00, carry_out=1, overflow=0 → after that edge Z=1, C=1, N=0, V=0, and p_out=8'h27.
- Back-to-back updates:
  - cycle 1: upd_en with mask 4'hF; cycle 2: upd_en with mask 4'hA
  - ALU returns 8'h80 c=1, then 8'h01 c=0
  - → after first apply, N=1 C=1; after second, N=0 Z=0 and C stays 1.
- Collision: pending update with mask C and carry_out=0, plus flag_op=SEC on the same edge → C=1.
- PLP: plp_en with plp_data=8'hFF → all flags 1, p_out=8'hEF (php_brk=0) and 8'hFF (php_brk=1). irq_mask rises one edge after flag_i.
- Reset mid-op: upd_en, then reset on the next edge with alu_out=8'h00 → Z=0 and upd_pending=0 after reset, with no late Z update.
